// File: rtl/a_deser_rs232_prot8.sv
// RS232 receive deserializer: assembles LSB-first bytes on bit-centre strobes and
// routes them to calibration outputs (byte / byte-pair) or, once synchronised, to payload.
module a_deser_rs232_prot8 #(
   parameter logic [11:0] GAP_MAX = 12'd2048
) (
   input  logic        clk_ref,
   input  logic        rst_n,
   input  logic        r_di,
   input  logic        clk_rcpt,
   input  logic        sync_i,
   input  logic        restart,
   output logic [7:0]  data_demi,
   output logic        dv_demi,
   output logic [15:0] data,
   output logic        dv_data,
   output logic [7:0]  rx_byte,
   output logic        rx_dv,
   output logic        err_gap
);

   // Valid semantics: every dv/rx_dv/err_gap is a single-cycle pulse with no back-pressure;
   // the paired data register is updated in the same cycle the pulse rises and then held.

   // Only bits [7:1] are ever read: the oldest bit falls off when the byte completes.
   logic [7:1]  shift;
   logic [2:0]  bit_cnt;
   logic [11:0] gap_cnt;
   logic        demi_done;
   logic        half;
   logic [7:0]  low_q;

   logic [7:0]  rx_word;
   logic        byte_done;
   logic        gap_expire;

   assign rx_word    = {r_di, shift[7:1]};
   assign byte_done  = clk_rcpt && (bit_cnt == 3'd7);
   // A strobe in the expiry cycle takes priority, so expiry requires no strobe.
   assign gap_expire = !clk_rcpt && (bit_cnt != 3'd0) && (gap_cnt == GAP_MAX - 12'd1);

   // Bit assembly and gap watchdog.
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         err_gap <= 1'b0;
      end else begin
         err_gap <= 1'b0;
         if (restart) begin
            shift   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
         end else if (clk_rcpt) begin
            shift   <= rx_word[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            gap_cnt <= '0;
         end else if (gap_expire) begin
            shift   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            err_gap <= 1'b1;
         end else if (bit_cnt != 3'd0) begin
            gap_cnt <= gap_cnt + 12'd1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // Byte routing: payload when synchronised, otherwise the calibration sequence
   // (first byte alone, then low/high pairs).
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         demi_done <= 1'b0;
         half      <= 1'b0;
         low_q     <= '0;
         data_demi <= '0;
         dv_demi   <= 1'b0;
         data      <= '0;
         dv_data   <= 1'b0;
         rx_byte   <= '0;
         rx_dv     <= 1'b0;
      end else begin
         dv_demi <= 1'b0;
         dv_data <= 1'b0;
         rx_dv   <= 1'b0;
         if (restart) begin
            demi_done <= 1'b0;
            half      <= 1'b0;
            low_q     <= '0;
         end else if (byte_done) begin
            if (sync_i) begin
               // A held low byte is abandoned once the link is synchronised.
               rx_byte <= rx_word;
               rx_dv   <= 1'b1;
               half    <= 1'b0;
            end else if (!demi_done) begin
               data_demi <= rx_word;
               dv_demi   <= 1'b1;
               demi_done <= 1'b1;
            end else if (!half) begin
               low_q <= rx_word;
               half  <= 1'b1;
            end else begin
               data    <= {rx_word, low_q};
               dv_data <= 1'b1;
               half    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/a_deser_rs232_prot8.md
# a_deser_rs232_prot8

Receive-side deserializer for the RS232 link. It samples the serial line `r_di` on each bit-centre strobe `clk_rcpt` produced by the clock generator and assembles 8-bit bytes, LSB first. It returns the calibration bytes to the clock generator's protocol checker as `data_demi`/`dv_demi` and as paired 16-bit words `data`/`dv_data`. Once the link is synchronised (`sync_i`), it delivers single payload bytes to the management logic.

## Interface
- `GAP_MAX`, default 12'd2048: `clk_ref` cycles allowed between strobes inside a byte before the partial byte is aborted.
- `clk_ref`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `r_di`  in  1  serial line, already synchronised to `clk_ref`.
- `clk_rcpt`  in  1  one-cycle bit-centre strobe; 8 strobes per frame, one per data bit.
- `sync_i`  in  1  link synchronised (clock generator `sync_o`); selects payload mode.
- `restart`  in  1  synchronous clear pulse; re-arms calibration.
- `data_demi`  out  8  first calibration byte.
- `dv_demi`  out  1  one-cycle valid for `data_demi`.
- `data`  out  16  calibration byte pair; `[7:0]` is the first byte, `[15:8]` the second.
- `dv_data`  out  1  one-cycle valid for `data`.
- `rx_byte`  out  8  payload byte.
- `rx_dv`  out  1  one-cycle valid for `rx_byte`.
- `err_gap`  out  1  one-cycle pulse when a partial byte is aborted.

## Operation
- State:
  - `shift[7:0]`: shift register.
  - `bit_cnt[2:0]`: bits received in the current byte.
  - `gap_cnt[11:0]`: cycles since the last strobe.
  - `demi_done`: the `data_demi` byte has been delivered.
  - `half`: the low byte of a calibration pair is held.
  - `low_q[7:0]`: held low byte.
- On a `clk_rcpt` cycle:
  - `shift <= {r_di, shift[7:1]}`, `bit_cnt <= bit_cnt+1` (3-bit wrap), `gap_cnt <= 0`.
  - When `bit_cnt==7` on that strobe, the completed byte is `{r_di, shift[7:1]}` and `bit_cnt` wraps to 0.
- Byte routing on completion:
  - `sync_i`=1: `rx_byte <= byte`, `rx_dv <= 1`; `half` cleared.
  - `sync_i`=0, `demi_done`=0: `data_demi <= byte`, `dv_demi <= 1`, `demi_done <= 1`.
  - `sync_i`=0, `demi_done`=1, `half`=0: `low_q <= byte`, `half <= 1`, no output.
  - `sync_i`=0, `demi_done`=1, `half`=1: `data <= {byte, low_q}`, `dv_data <= 1`, `half <= 0`.
- Gap watchdog:
  - When `bit_cnt!=0` and no strobe, `gap_cnt` increments.
  - When `gap_cnt==GAP_MAX-1`: `bit_cnt <= 0`, `shift <= 0`, `gap_cnt <= 0`, `err_gap <= 1`; no byte is emitted.
  - When `bit_cnt==0`, `gap_cnt` is held at 0.
- `restart`: clears `shift`, `bit_cnt`, `gap_cnt`, `demi_done`, `half`, `low_q` and all `dv` outputs. Data output registers hold their values.
- Simultaneous events:
  - Strobe and watchdog expiry in the same cycle: the strobe wins, and no error is raised.
  - `restart` and a strobe in the same cycle: `restart` wins, and the strobe is discarded.
  - `sync_i` rising while `half`=1: the held low byte is dropped and the next byte goes to `rx_byte`.

## Timing
- Reset values: every output is 0; `shift`, `bit_cnt`, `gap_cnt`, `demi_done`, `half`, `low_q` are 0.
- Valid latency: each `dv`/`rx_dv` rises on the cycle after the 8th strobe and is high for exactly one cycle.
- Data outputs change only in the cycle their `dv` rises and are stable until the next update.
- Strobes one cycle apart are handled without loss; there is no throughput limit.
- `err_gap` is asserted the cycle after `gap_cnt` reaches `GAP_MAX-1`, i.e. `GAP_MAX` cycles after the last strobe.
- No combinational path from input to output; all outputs are registered.

## Test plan
- Reset, then 8 strobes with `r_di` = bits of 8'hA5 LSB first and `sync_i`=0 -> `data_demi`=8'hA5 and `dv_demi`=1 for one cycle, one cycle after the last strobe; `dv_data`=0.
- Then bytes 8'h55 and 8'hFF -> no output after the first byte; after the second, `data`=16'hFF55 with a one-cycle `dv_data`; a third byte produces no `dv_data`.
- `sync_i`=1, bytes 8'h3C and 8'hC3 -> `rx_byte`=8'h3C then 8'hC3, each with a one-cycle `rx_dv`; `dv_data` and `dv_demi` stay 0.
- 3 strobes then silence with `GAP_MAX`=16 -> `err_gap` pulses once, 16 cycles after the last strobe. A following full byte 8'h81 is received correctly, with no leftover bits.
- Strobe on the exact cycle the gap counter expires -> no `err_gap`, and `bit_cnt` advances.
- `restart` while `half`=1 -> the next byte goes to `data_demi` with `dv_demi`, not to `data`. Async `rst_n` asserted mid-byte -> all outputs go to 0 immediately.
